// File: rtl/sw_bank_scheduler.sv
// Job controller that walks one ScoreBank through penalties, query, target streaming and result drain.
// Defining SW_SCHED_STATS_EN adds a stall_cycles output counting full-bank backpressure in STREAM.

module sw_bank_scheduler #(
    parameter int SCORE_WIDTH = 12,
    parameter int ID_WIDTH    = 48,
    parameter int LEN_WIDTH   = 12,
    parameter int SEQ_LENGTH  = 128,
    parameter int MODULES     = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic                                             start,
    input  logic [CNT_WIDTH-1:0]                             nr_targets,
    input  logic [2*SEQ_LENGTH-1:0]                          q_data,
    input  logic [LEN_WIDTH-1:0]                             q_len,
    input  logic                                             t_valid,
    output logic                                             t_ready,
    input  logic [2*SEQ_LENGTH-1:0]                          t_data,
    input  logic [LEN_WIDTH-1:0]                             t_len,
    input  logic                                             bank_ready,
    input  logic                                             bank_full,
    input  logic [2*MODULES-1:0]                             bank_vld,
    output logic                                             bank_ld_penalties,
    output logic                                             bank_ld_sequence,
    output logic [2+ID_WIDTH+LEN_WIDTH+2*SEQ_LENGTH-1:0]     bank_data_in,
    output logic                                             busy,
    output logic                                             done,
    output logic                                             err_overrun,
    output logic [CNT_WIDTH-1:0]                             loaded_cnt,
    output logic [CNT_WIDTH-1:0]                             result_cnt
`ifdef SW_SCHED_STATS_EN
    ,
    output logic [31:0]                                      stall_cycles
`endif
);

    localparam int PAY_W = 2 * SEQ_LENGTH;
    localparam int VLD_W = 2 * MODULES;
    localparam int PC_W  = $clog2(VLD_W + 1);
    localparam int SUM_W = CNT_WIDTH + PC_W;

    // Sequence IDs are taken from the target counter, so the ID field must be able to hold it.
    if (ID_WIDTH < CNT_WIDTH || SCORE_WIDTH < 1) begin : g_bad_params
        $error("sw_bank_scheduler: ID_WIDTH must be at least CNT_WIDTH and SCORE_WIDTH positive");
    end

    typedef enum logic [2:0] {IDLE, PEN, QUERY, STREAM, DRAIN, DONE} state_t;

    state_t                 state;
    state_t                 next_state;
    logic [CNT_WIDTH-1:0]   nr_q;
    logic [PAY_W-1:0]       q_data_q;
    logic [LEN_WIDTH-1:0]   q_len_q;
    logic                   start_ok;
    logic                   query_go;
    logic                   t_fire;
    logic                   last_load;
    logic [PC_W-1:0]        vld_pop;
    logic [SUM_W-1:0]       res_sum;

    always_comb begin
        start_ok  = (state == IDLE) && start;
        query_go  = (state == QUERY) && bank_ready;
        t_fire    = t_valid && t_ready;
        last_load = ((loaded_cnt + CNT_WIDTH'(1)) == nr_q);
        vld_pop   = '0;
        for (int i = 0; i < VLD_W; i++) begin
            vld_pop = vld_pop + PC_W'(bank_vld[i]);
        end
        res_sum   = SUM_W'(result_cnt) + SUM_W'(vld_pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = PEN;
            PEN:     next_state = QUERY;
            QUERY:   if (bank_ready) next_state = (nr_q == '0) ? DRAIN : STREAM;
            STREAM:  if (t_fire && last_load) next_state = DRAIN;
            DRAIN:   if (result_cnt == nr_q) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // full gates t_ready combinationally, so the bank has to absorb the load that raced its full flag.
    always_comb begin
        bank_ld_penalties = (state == PEN);
        done              = (state == DONE);
        busy              = (state != IDLE);
        t_ready           = (state == STREAM) && !bank_full && (loaded_cnt < nr_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            nr_q             <= '0;
            q_data_q         <= '0;
            q_len_q          <= '0;
            loaded_cnt       <= '0;
            result_cnt       <= '0;
            err_overrun      <= 1'b0;
            bank_ld_sequence <= 1'b0;
            bank_data_in     <= '0;
        end else begin
            bank_ld_sequence <= query_go || t_fire;
            if (start_ok) begin
                nr_q        <= nr_targets;
                q_data_q    <= q_data;
                q_len_q     <= q_len;
                loaded_cnt  <= '0;
                result_cnt  <= '0;
                err_overrun <= 1'b0;
            end else begin
                if (state != IDLE) begin
                    if (res_sum > SUM_W'(nr_q)) begin
                        result_cnt  <= nr_q;
                        err_overrun <= 1'b1;
                    end else begin
                        result_cnt  <= res_sum[CNT_WIDTH-1:0];
                    end
                end
                if (t_fire) begin
                    loaded_cnt <= loaded_cnt + CNT_WIDTH'(1);
                end
            end
            if (query_go) begin
                bank_data_in <= {2'b01, {ID_WIDTH{1'b0}}, q_len_q, q_data_q};
            end else if (t_fire) begin
                bank_data_in <= {2'b10, ID_WIDTH'(loaded_cnt) + ID_WIDTH'(1), t_len, t_data};
            end
        end
    end

`ifdef SW_SCHED_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
        end else if (start_ok) begin
            stall_cycles <= '0;
        end else if ((state == STREAM) && t_valid && bank_full && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sw_bank_scheduler.sv
// Directed bench for sw_bank_scheduler: expected bank words are queued as jobs are driven and a
// negedge monitor pops and compares them whenever the scheduler strobes bank_ld_sequence.

module tb_sw_bank_scheduler;

    localparam int SCORE_WIDTH = 12;
    localparam int ID_WIDTH    = 16;
    localparam int LEN_WIDTH   = 8;
    localparam int SEQ_LENGTH  = 8;
    localparam int MODULES     = 2;
    localparam int CNT_WIDTH   = 8;
    localparam int DW          = 2 + ID_WIDTH + LEN_WIDTH + 2 * SEQ_LENGTH;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start;
    logic [CNT_WIDTH-1:0]   nr_targets;
    logic [15:0]            q_data;
    logic [7:0]             q_len;
    logic                   t_valid;
    logic                   t_ready;
    logic [15:0]            t_data;
    logic [7:0]             t_len;
    logic                   bank_ready;
    logic                   bank_full;
    logic [3:0]             bank_vld;
    logic                   bank_ld_penalties;
    logic                   bank_ld_sequence;
    logic [DW-1:0]          bank_data_in;
    logic                   busy;
    logic                   done;
    logic                   err_overrun;
    logic [CNT_WIDTH-1:0]   loaded_cnt;
    logic [CNT_WIDTH-1:0]   result_cnt;
`ifdef SW_SCHED_STATS_EN
    logic [31:0]            stall_cycles;
`endif

    int            n_checks = 0;
    int            n_errors = 0;
    int            pen_seen = 0;
    int            src_idx  = 1;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_w;

    sw_bank_scheduler #(
        .SCORE_WIDTH (SCORE_WIDTH),
        .ID_WIDTH    (ID_WIDTH),
        .LEN_WIDTH   (LEN_WIDTH),
        .SEQ_LENGTH  (SEQ_LENGTH),
        .MODULES     (MODULES),
        .CNT_WIDTH   (CNT_WIDTH)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .nr_targets        (nr_targets),
        .q_data            (q_data),
        .q_len             (q_len),
        .t_valid           (t_valid),
        .t_ready           (t_ready),
        .t_data            (t_data),
        .t_len             (t_len),
        .bank_ready        (bank_ready),
        .bank_full         (bank_full),
        .bank_vld          (bank_vld),
        .bank_ld_penalties (bank_ld_penalties),
        .bank_ld_sequence  (bank_ld_sequence),
        .bank_data_in      (bank_data_in),
        .busy              (busy),
        .done              (done),
        .err_overrun       (err_overrun),
        .loaded_cnt        (loaded_cnt),
        .result_cnt        (result_cnt)
`ifdef SW_SCHED_STATS_EN
        ,
        .stall_cycles      (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Target k of a job carries payload A5_kk and length 20h+k, and must appear with id k.
    function automatic logic [DW-1:0] tgt_word(input int idx);
        logic [7:0] i8;
        i8 = 8'(idx);
        return {2'b10, 8'h00, i8, 8'h20 + i8, 8'hA5, i8};
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then record any handshake the next rise will take.
    task automatic apply_stimulus(input logic st, input logic tv, input logic full,
                                  input logic rdy, input logic [3:0] vld);
        @(negedge clk);
        start      = st;
        t_valid    = tv;
        bank_full  = full;
        bank_ready = rdy;
        bank_vld   = vld;
        t_data     = {8'hA5, 8'(src_idx)};
        t_len      = 8'h20 + 8'(src_idx);
        #1;
        if (t_valid && t_ready) begin
            exp_q.push_back(tgt_word(src_idx));
            src_idx++;
        end
    endtask

    task automatic start_job(input logic [7:0] nr, input logic [15:0] qd, input logic [7:0] ql);
        nr_targets = nr;
        q_data     = qd;
        q_len      = ql;
        src_idx    = 1;
        exp_q.push_back({2'b01, 16'h0000, ql, qd});
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'b0000);
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (bank_ld_penalties === 1'b1) pen_seen++;
            if (bank_ld_sequence === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("[TB] FAIL sb_unexpected: strobe with data %0h, required no strobe", bank_data_in);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (bank_data_in !== exp_w) begin
                        n_errors++;
                        $display("[TB] FAIL sb_data: got %0h, required %0h", bank_data_in, exp_w);
                    end
                end
            end
        end
    end

    initial begin
        rst        = 1'b0;
        start      = 1'b0;
        nr_targets = '0;
        q_data     = '0;
        q_len      = '0;
        t_valid    = 1'b0;
        t_data     = '0;
        t_len      = '0;
        bank_ready = 1'b0;
        bank_full  = 1'b0;
        bank_vld   = '0;

        repeat (2) @(negedge clk);
        #1;
        check_output("rst_busy",   64'(busy), 64'd0);
        check_output("rst_done",   64'(done), 64'd0);
        check_output("rst_tready", 64'(t_ready), 64'd0);
        check_output("rst_ldpen",  64'(bank_ld_penalties), 64'd0);
        check_output("rst_ldseq",  64'(bank_ld_sequence), 64'd0);
        check_output("rst_data",   64'(bank_data_in), 64'd0);
        check_output("rst_loaded", 64'(loaded_cnt), 64'd0);
        check_output("rst_result", 64'(result_cnt), 64'd0);
        check_output("rst_err",    64'(err_overrun), 64'd0);
        rst = 1'b1;

        $display("[TB] job 1: nr=3, no backpressure");
        start_job(8'd3, 16'h1234, 8'h08);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'b0000);
        check_output("j1_busy",   64'(busy), 64'd1);
        check_output("j1_pen",    64'(bank_ld_penalties), 64'd1);
        check_output("j1_tready_pen", 64'(t_ready), 64'd0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'b0000);
        check_output("j1_pen_once", 64'(bank_ld_penalties), 64'd0);
        repeat (3) apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'b0000);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'b0001);
        check_output("j1_loaded", 64'(loaded_cnt), 64'd3);
        check_output("j1_b2b", 64'(exp_q.size()), 64'd0);
        check_output("j1_tready_drain", 64'(t_ready), 64'd0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'b0001);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'b0001);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'b0000);
        check_output("j1_result", 64'(result_cnt), 64'd3);
        check_output("j1_done_early", 64'(done), 64'd0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'b0000);
        check_output("j1_done", 64'(done), 64'd1);
        check_output("j1_busy_done", 64'(busy), 64'd1);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'b0000);
        check_output("j1_done_pulse", 64'(done), 64'd0);
        check_output("j1_idle", 64'(busy), 64'd0);
        check_output("j1_pen_count", 64'(pen_seen), 64'd1);

        $display("[TB] job 2: nr=4, bank full for 10 cycles, start while busy");
        start_job(8'd4, 16'hBEEF, 8'h10);
        repeat (4) apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'b0000);
        nr_targets = 8'd7;
        for (int i = 0; i < 10; i++) begin
            apply_stimulus((i == 3), 1'b1, 1'b1, 1'b1, 4'b0000);
            check_output("j2_stall_tready", 64'(t_ready), 64'd0);
        end
        check_output("j2_loaded_stall", 64'(loaded_cnt), 64'd2);
        check_output("j2_result_stall", 64'(result_cnt), 64'd0);
        repeat (2) apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'b0000);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'b0011);
        check_output("j2_loaded", 64'(loaded_cnt), 64'd4);
        check_output("j2_sb_empty", 64'(exp_q.size()), 64'd0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'b1100);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'b0000);
        check_output("j2_result", 64'(result_cnt), 64'd4);
        check_output("j2_err", 64'(err_overrun), 64'd0);
`ifdef SW_SCHED_STATS_EN
        check_output("j2_stall_cycles", 64'(stall_cycles), 64'd10);
`endif
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'b0000);
        check_output("j2_done", 64'(done), 64'd1);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'b0000);
        check_output("j2_idle", 64'(busy), 64'd0);
        check_output("j2_pen_count", 64'(pen_seen), 64'd2);

        $display("[TB] job 3: nr=0, bank not ready for two cycles");
        start_job(8'd0, 16'h0F0F, 8'h04);
        repeat (2) apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
        check_output("j3_query_wait", 64'(exp_q.size()), 64'd1);
        check_output("j3_tready_q", 64'(t_ready), 64'd0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'b0000);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'b0000);
        check_output("j3_sb_empty", 64'(exp_q.size()), 64'd0);
        check_output("j3_tready_drain", 64'(t_ready), 64'd0);
        check_output("j3_done_early", 64'(done), 64'd0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'b0000);
        check_output("j3_done", 64'(done), 64'd1);
        check_output("j3_loaded", 64'(loaded_cnt), 64'd0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'b0000);
        check_output("j3_idle", 64'(busy), 64'd0);

        $display("[TB] job 4: nr=2 with result overrun");
        start_job(8'd2, 16'h5555, 8'h02);
        repeat (4) apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'b0000);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'b0011);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'b0001);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'b0000);
        check_output("j4_result_sat", 64'(result_cnt), 64'd2);
        check_output("j4_err", 64'(err_overrun), 64'd1);
        check_output("j4_done", 64'(done), 64'd1);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'b1111);
        check_output("j4_err_sticky", 64'(err_overrun), 64'd1);
        check_output("j4_idle_ignore", 64'(result_cnt), 64'd2);
        check_output("j4_idle", 64'(busy), 64'd0);

        $display("[TB] job 5: reset in the middle of streaming");
        start_job(8'd3, 16'h7777, 8'h03);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'b0000);
        check_output("j5_err_clear", 64'(err_overrun), 64'd0);
        check_output("j5_result_clear", 64'(result_cnt), 64'd0);
        repeat (2) apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'b0000);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
        check_output("j5_loaded_one", 64'(loaded_cnt), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check_output("j5_rst_busy",   64'(busy), 64'd0);
        check_output("j5_rst_tready", 64'(t_ready), 64'd0);
        check_output("j5_rst_ldseq",  64'(bank_ld_sequence), 64'd0);
        check_output("j5_rst_data",   64'(bank_data_in), 64'd0);
        check_output("j5_rst_loaded", 64'(loaded_cnt), 64'd0);
        check_output("j5_rst_result", 64'(result_cnt), 64'd0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'b0000);
        rst = 1'b1;
        start_job(8'd1, 16'hCAFE, 8'h0C);
        repeat (3) apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'b0000);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'b0100);
        check_output("j5_fresh_loaded", 64'(loaded_cnt), 64'd1);
        check_output("j5_fresh_sb", 64'(exp_q.size()), 64'd0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'b0000);
        check_output("j5_fresh_result", 64'(result_cnt), 64'd1);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'b0000);
        check_output("j5_fresh_done", 64'(done), 64'd1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
        check_output("j5_fresh_idle", 64'(busy), 64'd0);

        check_output("sb_final_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
